// File: rtl/audio_dualport_onchip_memory.sv
// Purpose : true-dual-port byte-enabled RAM, s1 = CPU port, s2 = wavetable engine port.
// Latency : READ_LATENCY (1 or 2) enabled cycles from accepted read to readdatavalid.
// Backpressure: none; en = clken & ~reset_req freezes all state, requests seen while en = 0 are dropped.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset (outputs, pipeline, counter; not RAM)
//   clken, reset_req    : global enable terms
//   freeze              : suppresses writes on both ports, reads still complete
//   sN_address/chipselect/read/write/byteenable/writedata : Avalon-MM slave request, N = 1, 2
//   sN_readdata/readdatavalid : registered read response, data holds while valid is low
//   collision_count     : saturating count of same-address write/write collisions
//
// INIT_FILE names the hex image handed to the target's RAM-initialisation flow;
// this behavioural array itself starts unloaded.
module audio_dualport_onchip_memory #(
    parameter int    DATA_WIDTH   = 16,
    parameter int    ADDR_WIDTH   = 17,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic                    freeze,

    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,

    output logic [15:0]             collision_count
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage: no reset, contents survive reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Both ports gathered into index 0 (s1) and 1 (s2) so the per-port logic is written once.
    logic                       en;
    logic [1:0]                 wr;
    logic [1:0]                 rd;
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][NB-1:0]         be;
    logic [1:0][DATA_WIDTH-1:0] wdat;
    logic                       collide;

    assign en = clken & ~reset_req;

    always_comb begin
        addr[0] = s1_address;
        addr[1] = s2_address;
        be[0]   = s1_byteenable;
        be[1]   = s2_byteenable;
        wdat[0] = s1_writedata;
        wdat[1] = s2_writedata;
        wr[0]   = s1_chipselect & s1_write & ~freeze;
        wr[1]   = s2_chipselect & s2_write & ~freeze;
        // A read flagged together with a write is a write only.
        rd[0]   = s1_chipselect & s1_read & ~s1_write;
        rd[1]   = s2_chipselect & s2_read & ~s2_write;
    end

    assign collide = wr[0] & wr[1] & (addr[0] == addr[1]);

    // Post-write view of each read address: start from the stored word and overlay
    // the enabled lanes of any same-cycle write. s2 is overlaid first so s1 wins a
    // lane both ports enable, matching the resolution applied to the array below.
    logic [1:0][DATA_WIDTH-1:0] fwd;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd[p] = mem_q[addr[p]];
            for (int q = 1; q >= 0; q--) begin
                if (wr[q] && (addr[q] == addr[p])) begin
                    for (int l = 0; l < NB; l++) begin
                        if (be[q][l]) begin
                            fwd[p][l*8 +: 8] = wdat[q][l*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Array write: s1 is issued last so its lanes override s2 on a collision.
    always_ff @(posedge clk) begin
        if (!reset && en) begin
            for (int q = 1; q >= 0; q--) begin
                if (wr[q]) begin
                    for (int l = 0; l < NB; l++) begin
                        if (be[q][l]) begin
                            mem_q[addr[q]][l*8 +: 8] <= wdat[q][l*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // First response stage and collision counter.
    logic [1:0]                 vld1_q, vld1_d;
    logic [1:0][DATA_WIDTH-1:0] dat1_q, dat1_d;
    logic [15:0]                cnt_q, cnt_d;

    always_comb begin
        vld1_d = vld1_q;
        dat1_d = dat1_q;
        cnt_d  = cnt_q;
        if (en) begin
            vld1_d = rd;
            for (int p = 0; p < 2; p++) begin
                if (rd[p]) begin
                    dat1_d[p] = fwd[p];
                end
            end
            if (collide && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld1_q <= '0;
            dat1_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld1_q <= vld1_d;
            dat1_q <= dat1_d;
            cnt_q  <= cnt_d;
        end
    end

    logic [1:0]                 out_vld;
    logic [1:0][DATA_WIDTH-1:0] out_dat;

    if (READ_LATENCY == 2) begin : g_lat2
        // Extra output register; it only advances when the first stage holds a valid word
        // so readdata keeps its last value through idle cycles.
        logic [1:0]                 vld2_q, vld2_d;
        logic [1:0][DATA_WIDTH-1:0] dat2_q, dat2_d;

        always_comb begin
            vld2_d = vld2_q;
            dat2_d = dat2_q;
            if (en) begin
                vld2_d = vld1_q;
                for (int p = 0; p < 2; p++) begin
                    if (vld1_q[p]) begin
                        dat2_d[p] = dat1_q[p];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld2_q <= '0;
                dat2_q <= '0;
            end else begin
                vld2_q <= vld2_d;
                dat2_q <= dat2_d;
            end
        end

        assign out_vld = vld2_q;
        assign out_dat = dat2_q;
    end else begin : g_lat1
        assign out_vld = vld1_q;
        assign out_dat = dat1_q;
    end

    assign s1_readdatavalid = out_vld[0];
    assign s1_readdata      = out_dat[0];
    assign s2_readdatavalid = out_vld[1];
    assign s2_readdata      = out_dat[1];
    assign collision_count  = cnt_q;

endmodule

// File: tb/tb_audio_dualport_onchip_memory.sv
// Purpose : checks audio_dualport_onchip_memory at READ_LATENCY 1 (dut a) and 2 (dut b), shared stimulus.
// Latency : one clock per cycle() call; outputs sampled on the falling edge.
// Backpressure: none; enable and freeze are driven directly.
module tb_audio_dualport_onchip_memory;

    logic        clk = 1'b0;
    logic        reset, clken, reset_req, freeze;
    logic [7:0]  s1_address, s2_address;
    logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [1:0]  s1_byteenable, s2_byteenable;
    logic [15:0] s1_writedata, s2_writedata;

    logic [15:0] a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata;
    logic        a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid;
    logic [15:0] a_cnt, b_cnt;

    always #5 clk = ~clk;

    audio_dualport_onchip_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(1), .INIT_FILE("")) u_a (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_readdatavalid),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_readdatavalid),
        .collision_count(a_cnt));

    audio_dualport_onchip_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(2), .INIT_FILE("")) u_b (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_readdatavalid),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_readdatavalid),
        .collision_count(b_cnt));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: word array, history of the last two accepted-read results per
    // port (counted in enabled edges), and the expected output register per latency.
    logic [15:0] mmem [256];
    int unsigned mcnt;
    int          nen;
    bit          hv [2][2];
    logic [15:0] hd [2][2];
    bit          ev [2][2];
    logic [15:0] ed [2][2];

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] b);
        logic [15:0] r;
        r = old;
        if (b[0]) r[7:0]  = nw[7:0];
        if (b[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    task automatic model_edge();
        bit          w1, w2, r1, r2;
        if (reset) begin
            mcnt = 0;
            nen  = 0;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    hv[i][j] = 0; hd[i][j] = '0; ev[i][j] = 0; ed[i][j] = '0;
                end
        end else if (clken && !reset_req) begin
            w1 = s1_chipselect && s1_write && !freeze;
            w2 = s2_chipselect && s2_write && !freeze;
            r1 = s1_chipselect && s1_read && !s1_write;
            r2 = s2_chipselect && s2_read && !s2_write;
            if (w1 && w2 && s1_address == s2_address && mcnt < 65535) mcnt++;
            // s1 takes every lane it enables; s2 keeps only the lanes s1 leaves alone
            if (w2) mmem[s2_address] = merge(mmem[s2_address], s2_writedata, s2_byteenable);
            if (w1) mmem[s1_address] = merge(mmem[s1_address], s1_writedata, s1_byteenable);
            for (int p = 0; p < 2; p++) begin
                hv[p][1] = hv[p][0];
                hd[p][1] = hd[p][0];
            end
            hv[0][0] = r1; hd[0][0] = mmem[s1_address];
            hv[1][0] = r2; hd[1][0] = mmem[s2_address];
            nen++;
            for (int l = 0; l < 2; l++)
                for (int p = 0; p < 2; p++) begin
                    if (nen > l && hv[p][l]) begin
                        ev[l][p] = 1;
                        ed[l][p] = hd[p][l];
                    end else begin
                        ev[l][p] = 0;
                    end
                end
        end
    endtask

    task automatic model_check();
        chk("m_a_s1_vld", 16'(a_s1_readdatavalid), 16'(ev[0][0]));
        chk("m_a_s1_dat", a_s1_readdata, ed[0][0]);
        chk("m_a_s2_vld", 16'(a_s2_readdatavalid), 16'(ev[0][1]));
        chk("m_a_s2_dat", a_s2_readdata, ed[0][1]);
        chk("m_b_s1_vld", 16'(b_s1_readdatavalid), 16'(ev[1][0]));
        chk("m_b_s1_dat", b_s1_readdata, ed[1][0]);
        chk("m_b_s2_vld", 16'(b_s2_readdatavalid), 16'(ev[1][1]));
        chk("m_b_s2_dat", b_s2_readdata, ed[1][1]);
        chk("m_a_cnt", a_cnt, 16'(mcnt));
        chk("m_b_cnt", b_cnt, 16'(mcnt));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        model_check();
    endtask

    task automatic idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_byteenable = 2'b00; s1_address = '0; s1_writedata = '0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_byteenable = 2'b00; s2_address = '0; s2_writedata = '0;
        freeze = 0;
    endtask

    typedef struct {
        logic c1, r1, w1; logic [1:0] b1; logic [7:0] a1; logic [15:0] d1;
        logic c2, r2, w2; logic [1:0] b2; logic [7:0] a2; logic [15:0] d2;
        logic frz;
        logic ev1; logic [15:0] ed1; logic ev2; logic [15:0] ed2; logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // Expected values are for the READ_LATENCY=1 instance, sampled after each row's edge.
        tbl[0]  = '{1,0,1,2'b11,8'h10,16'hBEEF, 0,0,0,2'b00,8'h00,16'h0000, 0, 0,16'h0000, 0,16'h0000, 16'd0};
        tbl[1]  = '{0,0,0,2'b00,8'h00,16'h0000, 1,1,0,2'b00,8'h10,16'h0000, 0, 0,16'h0000, 1,16'hBEEF, 16'd0};
        tbl[2]  = '{1,0,1,2'b01,8'h20,16'h1122, 1,0,1,2'b11,8'h20,16'h3344, 0, 0,16'h0000, 0,16'hBEEF, 16'd1};
        tbl[3]  = '{1,1,0,2'b00,8'h20,16'h0000, 0,0,0,2'b00,8'h00,16'h0000, 0, 1,16'h3322, 0,16'hBEEF, 16'd1};
        tbl[4]  = '{0,0,0,2'b00,8'h00,16'h0000, 1,0,1,2'b11,8'h30,16'h1234, 0, 0,16'h3322, 0,16'hBEEF, 16'd1};
        tbl[5]  = '{1,0,1,2'b10,8'h30,16'h5555, 1,1,0,2'b00,8'h30,16'h0000, 0, 0,16'h3322, 1,16'h5534, 16'd1};
        tbl[6]  = '{0,0,0,2'b00,8'h00,16'h0000, 1,0,1,2'b11,8'h40,16'h0000, 0, 0,16'h3322, 0,16'h5534, 16'd1};
        tbl[7]  = '{1,0,1,2'b11,8'h40,16'hFFFF, 0,0,0,2'b00,8'h00,16'h0000, 1, 0,16'h3322, 0,16'h5534, 16'd1};
        tbl[8]  = '{1,1,0,2'b00,8'h40,16'h0000, 0,0,0,2'b00,8'h00,16'h0000, 0, 1,16'h0000, 0,16'h5534, 16'd1};
        tbl[9]  = '{1,0,1,2'b11,8'h50,16'hFFFF, 1,0,1,2'b11,8'h50,16'hEEEE, 1, 0,16'h0000, 0,16'h5534, 16'd1};
        tbl[10] = '{1,0,1,2'b00,8'h60,16'hFFFF, 1,1,1,2'b11,8'h61,16'h7777, 0, 0,16'h0000, 0,16'h5534, 16'd1};
        tbl[11] = '{1,1,0,2'b00,8'h60,16'h0000, 1,1,0,2'b00,8'h61,16'h0000, 0, 1,16'hA060, 1,16'h7777, 16'd1};
        tbl[12] = '{1,1,0,2'b00,8'hFF,16'h0000, 1,1,0,2'b00,8'hFF,16'h0000, 0, 1,16'hA0FF, 1,16'hA0FF, 16'd1};
        tbl[13] = '{1,0,1,2'b10,8'h70,16'hAB00, 1,0,1,2'b01,8'h70,16'h00CD, 0, 0,16'hA0FF, 0,16'hA0FF, 16'd2};
        tbl[14] = '{1,1,0,2'b00,8'h70,16'h0000, 0,1,0,2'b00,8'h70,16'h0000, 0, 1,16'hABCD, 0,16'hA0FF, 16'd2};

        idle();
        reset = 1; clken = 1; reset_req = 0;
        cycle();
        cycle();
        chk("rst_a_s1_vld", 16'(a_s1_readdatavalid), 16'd0);
        chk("rst_a_s1_dat", a_s1_readdata, 16'd0);
        chk("rst_b_s2_dat", b_s2_readdata, 16'd0);
        chk("rst_cnt", a_cnt, 16'd0);
        reset = 0;

        // Fill every word with A000 + address (s1 low half, s2 high half).
        for (int a = 0; a < 128; a++) begin
            s1_chipselect = 1; s1_write = 1; s1_byteenable = 2'b11;
            s1_address = 8'(a); s1_writedata = 16'hA000 + 16'(a);
            s2_chipselect = 1; s2_write = 1; s2_byteenable = 2'b11;
            s2_address = 8'(a + 128); s2_writedata = 16'hA000 + 16'(a + 128);
            cycle();
        end
        idle();

        for (int i = 0; i < 15; i++) begin
            s1_chipselect = tbl[i].c1; s1_read = tbl[i].r1; s1_write = tbl[i].w1;
            s1_byteenable = tbl[i].b1; s1_address = tbl[i].a1; s1_writedata = tbl[i].d1;
            s2_chipselect = tbl[i].c2; s2_read = tbl[i].r2; s2_write = tbl[i].w2;
            s2_byteenable = tbl[i].b2; s2_address = tbl[i].a2; s2_writedata = tbl[i].d2;
            freeze = tbl[i].frz;
            cycle();
            chk($sformatf("tbl%0d_s1_vld", i), 16'(a_s1_readdatavalid), 16'(tbl[i].ev1));
            chk($sformatf("tbl%0d_s1_dat", i), a_s1_readdata, tbl[i].ed1);
            chk($sformatf("tbl%0d_s2_vld", i), 16'(a_s2_readdatavalid), 16'(tbl[i].ev2));
            chk($sformatf("tbl%0d_s2_dat", i), a_s2_readdata, tbl[i].ed2);
            chk($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].ecnt);
        end
        idle();
        cycle();

        // Latency 2: reads of 0..3 back to back, valids one cycle after the latency-1 ones.
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i < 4) begin
                s1_chipselect = 1; s1_read = 1; s1_address = 8'(i);
            end
            cycle();
            chk($sformatf("lat2_vld%0d", i), 16'(b_s1_readdatavalid), 16'((i >= 1 && i <= 4) ? 1 : 0));
            if (i >= 1 && i <= 4) chk($sformatf("lat2_dat%0d", i), b_s1_readdata, 16'hA000 + 16'(i - 1));
        end

        // Stall by clken (m=0) then reset_req (m=1) with a read in flight.
        for (int m = 0; m < 2; m++) begin
            idle();
            s1_chipselect = 1; s1_read = 1; s1_address = 8'h10;
            cycle();
            chk("stall_acc_b_vld", 16'(b_s1_readdatavalid), 16'd0);
            s1_address = 8'h20;
            if (m == 0) clken = 0; else reset_req = 1;
            for (int k = 0; k < 3; k++) begin
                cycle();
                chk("stall_b_vld", 16'(b_s1_readdatavalid), 16'd0);
                chk("stall_a_hold", a_s1_readdata, 16'hBEEF);
            end
            clken = 1; reset_req = 0;
            idle();
            cycle();
            chk("stall_rel_b_vld", 16'(b_s1_readdatavalid), 16'd1);
            chk("stall_rel_b_dat", b_s1_readdata, 16'hBEEF);
            chk("stall_drop_a_vld", 16'(a_s1_readdatavalid), 16'd0);
            cycle();
            chk("stall_end_b_vld", 16'(b_s1_readdatavalid), 16'd0);
        end

        // Reset while a latency-2 read is in flight.
        s1_chipselect = 1; s1_read = 1; s1_address = 8'h10;
        cycle();
        idle();
        reset = 1;
        cycle();
        chk("rstf_b_vld", 16'(b_s1_readdatavalid), 16'd0);
        chk("rstf_b_dat", b_s1_readdata, 16'd0);
        chk("rstf_a_dat", a_s1_readdata, 16'd0);
        chk("rstf_cnt", b_cnt, 16'd0);
        reset = 0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("rstf_after_vld", 16'(b_s1_readdatavalid), 16'd0);
        end

        // Counter saturation.
        s1_chipselect = 1; s1_write = 1; s1_byteenable = 2'b11; s1_address = 8'h80;
        s2_chipselect = 1; s2_write = 1; s2_byteenable = 2'b11; s2_address = 8'h80;
        for (int k = 0; k < 65534; k++) begin
            s1_writedata = 16'(k); s2_writedata = ~16'(k);
            cycle();
        end
        chk("sat_fffe", a_cnt, 16'hFFFE);
        cycle();
        chk("sat_ffff", a_cnt, 16'hFFFF);
        for (int k = 0; k < 3; k++) cycle();
        chk("sat_hold_a", a_cnt, 16'hFFFF);
        chk("sat_hold_b", b_cnt, 16'hFFFF);
        idle();

        // Randomized traffic against the model, addresses clustered to provoke collisions.
        for (int k = 0; k < 3000; k++) begin
            reset     = ($urandom_range(0, 199) == 0);
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            freeze    = ($urandom_range(0, 7) == 0);
            s1_chipselect = ($urandom_range(0, 3) != 0);
            s1_read       = 1'($urandom_range(0, 1));
            s1_write      = 1'($urandom_range(0, 1));
            s1_byteenable = 2'($urandom_range(0, 3));
            s1_address    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            s1_writedata  = 16'($urandom);
            s2_chipselect = ($urandom_range(0, 3) != 0);
            s2_read       = 1'($urandom_range(0, 1));
            s2_write      = 1'($urandom_range(0, 1));
            s2_byteenable = 2'($urandom_range(0, 3));
            s2_address    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            s2_writedata  = 16'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/audio_dualport_onchip_memory.md
Name: audio_dualport_onchip_memory

Overview:
- Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports.
- s1 is the Nios/CPU side; s2 is the synthesizer voice/wavetable engine.
- Successor to the fixed 16-bit, single-port, unregistered memory. Adds:
  - configurable width, depth and read latency;
  - readdatavalid pipeline;
  - cross-port write collision resolution with new-data forwarding;
  - a collision counter.
- Inferred behavioural RAM array, optionally preloaded from INIT_FILE.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 17, word address width; depth = 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
INIT_FILE, "", hex file loaded into the array at elaboration; empty means the array is not preloaded.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clken  in  1  global clock enable; when 0, the block is frozen
reset_req  in  1  reset request; gates the enable (en = clken & ~reset_req)
freeze  in  1  when 1, writes on both ports are suppressed; reads still complete
s1_address  in  ADDR_WIDTH  port 1 word address
s1_chipselect  in  1  port 1 select
s1_read  in  1  port 1 read request
s1_write  in  1  port 1 write request
s1_byteenable  in  DATA_WIDTH/8  port 1 byte lanes
s1_writedata  in  DATA_WIDTH  port 1 write data
s1_readdata  out  DATA_WIDTH  port 1 read data
s1_readdatavalid  out  1  port 1 read data qualifier
s2_* (address, chipselect, read, write, byteenable, writedata, readdata, readdatavalid): identical widths and semantics, port 2
collision_count  out  16  saturating count of same-address write/write collisions

Behaviour:
- One clock domain, clk.
- reset is synchronous, active-high, and has priority over en. On reset:
  - sN_readdata = 0, sN_readdatavalid = 0, collision_count = 0;
  - read pipeline flushed;
  - RAM contents are not cleared.
- Request decode, per port N:
  - wrN = sN_chipselect & sN_write & ~freeze;
  - rdN = sN_chipselect & sN_read & ~sN_write. A write with read asserted is treated as a write only; no readdatavalid is produced.
- en = 0: no state changes at all — no RAM writes, pipeline holds, outputs hold, counter holds. Requests presented while en = 0 are dropped, not queued.
- Write, en = 1: bytes with byteenable = 1 are updated at the next clk edge. byteenable = 0 leaves the array unchanged.
- Write/write collision: wr1 & wr2 & (s1_address == s2_address), per byte lane:
  - lane enabled on s1: s1 data written;
  - else lane enabled on s2: s2 data written;
  - else lane unchanged;
  - collision_count increments by 1 and saturates at 16'hFFFF.
- Read latency:
  - READ_LATENCY = 1: sN_readdata and sN_readdatavalid are registered one cycle after the accepted read.
  - READ_LATENCY = 2: an extra output register stage is added; data appears two enabled cycles after acceptance.
  - Reads are fully pipelined: one read per port per enabled cycle. Back-to-back reads produce back-to-back valids.
- Read-during-write, new-data rule. A read on either port to an address written in the same cycle (by either port) returns the post-write word:
  - enabled lanes carry the new data, after collision resolution;
  - other lanes carry the old data.
- When readdatavalid = 0, readdata holds its last value.
- freeze = 1 mid-burst: writes are dropped in those cycles; reads continue normally.
- reset_req = 1 behaves identically to clken = 0.
- Address wrap: none. Every address in 0..2**ADDR_WIDTH-1 is valid; the top address behaves like any other.

Test Plan:
- Config DATA_WIDTH=16, ADDR_WIDTH=8, READ_LATENCY=1. s1 writes 16'hBEEF to 8'h10 with byteenable 2'b11, then s2 reads 8'h10 → s2_readdatavalid one cycle later, s2_readdata = 16'hBEEF.
- Same-cycle writes to 8'h20: s1 writes 16'h1122 with be 2'b01; s2 writes 16'h3344 with be 2'b11 → readback 16'h3322; collision_count = 1.
- READ_LATENCY=2: s1 reads 8'h00..8'h03 on consecutive cycles, preloaded with 16'hA000+addr → valids on cycles 2..5; data 16'hA000, 16'hA001, 16'hA002, 16'hA003 in order.
- Same cycle: s1 writes 16'h5555 to 8'h30 with be 2'b10 (old contents 16'h1234); s2 reads 8'h30 → s2_readdata = 16'h5534.
- Pipeline control:
  - read issued, then clken = 0 for 3 cycles → valid delayed by exactly 3 cycles, data unchanged;
  - reset asserted with a read in flight → valid never asserts and outputs = 0.
- freeze = 1 during an s1 write of 16'hFFFF to 8'h40 (old 16'h0000) → readback 16'h0000; collision_count unchanged.
- Force 65536 collisions → collision_count saturates at 16'hFFFF.
